id_hazard_ctrl: RTL
===================

# id_hazard_ctrl

Pipeline interlock controller for the 5-stage MIPS core. It sits beside IDECODE and watches the IF/ID instruction, the ID/EX load and the EX/MEM branch resolution. It stalls PC and IF/ID and inserts an ID/EX bubble on load-use hazards. On a taken branch it flushes the wrong-path stages.

## Interface
- LOAD_STALL_CYCLES, 1, number of bubble cycles per load-use hazard; legal range 1–15.
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- IF_ID_instrout  input  32  instruction in decode. Fields used: [31:26] opcode, [25:21] rs, [20:16] rt.
- ID_EX_memread  input  1  the instruction in EX is a load.
- ID_EX_rt  input  5  destination register of that load.
- EX_MEM_PCSrc  input  1  taken branch resolved in MEM.
- pc_write  output  1  PC load enable.
- if_id_write  output  1  IF/ID register load enable.
- id_ex_bubble  output  1  forces the ID/EX wb/m/ex control fields to zero.
- if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  clear the named pipeline register on the next edge.
- stall_count, flush_count  output  32 each  event counters; present only with HAZ_STATS_EN.

## Operation
- Hazard term: hz = ID_EX_memread & (ID_EX_rt != 0) & ((ID_EX_rt == rs) | (uses_rt & ID_EX_rt == rt)).
- uses_rt is 1 for opcode 6'h00 (R-type), 6'h04 (beq) and 6'h2B (sw). It is 0 for all other opcodes, including lw 6'h23.
- FSM states:
  - RUN: normal operation.
  - STALL: extending a bubble. Down-counter cnt, width 4.
- RUN, hz=1:
  - Stall outputs assert combinationally in the same cycle: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - If LOAD_STALL_CYCLES>1, go to STALL with cnt=LOAD_STALL_CYCLES-2. Otherwise stay in RUN.
- STALL:
  - Stall outputs are asserted regardless of hz.
  - cnt decrements each cycle. At cnt==0, return to RUN next edge.
  - Returning to RUN re-evaluates hz.
- Branch, EX_MEM_PCSrc=1, in any state, has top priority:
  - if_id_flush, id_ex_flush and ex_mem_flush = 1 that cycle.
  - pc_write=1, if_id_write=1, id_ex_bubble=0, so the branch target loads.
  - Next state is RUN with cnt=0. Any pending stall is dropped because it belongs to the wrong path.
- Idle outputs: pc_write=1, if_id_write=1, all others 0.

## Timing
- Stall and flush outputs are combinational from the inputs and the current state. There is zero latency from the hazard term to the stall outputs.
- A load-use hazard costs exactly LOAD_STALL_CYCLES cycles with pc_write=0.
- Reset, asynchronous and effective immediately:
  - State = RUN, cnt=0, counters=0.
  - While rst_n=0: pc_write=0, if_id_write=0, id_ex_bubble=1, all flushes=0.
- Reset mid-STALL abandons the stall. The first cycle after release is RUN.
- hz and EX_MEM_PCSrc in the same cycle: the flush wins and no stall is counted.
- Back-to-back hazards: each return to RUN with hz=1 starts a new full stall.

## Configuration
- HAZ_STATS_EN defined:
  - stall_count increments on every cycle with pc_write=0 outside reset.
  - flush_count increments on every cycle with EX_MEM_PCSrc=1.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- HAZ_STATS_EN undefined: both ports and their registers are absent. All other behaviour is identical.

## Structure
- Shared header mips_defs.vh holds:
  - opcode constants OP_RTYPE, OP_BEQ, OP_LW, OP_SW;
  - state encodings HZ_RUN, HZ_STALL.
- IDECODE and the control unit use the same opcode constants.
- One sub-module, hz_detect: the combinational hz term and the uses_rt decode. The FSM, counter and stats live in the top module.

## Test plan
- Load-use on rs: ID_EX_memread=1, ID_EX_rt=2, IF_ID_instrout=32'h00430820 (add $1,$2,$3). Expect pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly 1 cycle, then idle outputs.
- Non-use of rt: ID_EX_rt=5, IF_ID_instrout=32'h8C050000 (lw rt=5). Expect no stall. The same test with ID_EX_rt=0 and rs=0 also gives no stall.
- Parameter sweep: LOAD_STALL_CYCLES=3 with the first stimulus. Expect 3 consecutive stall cycles and a STALL→RUN return. With HAZ_STATS_EN, stall_count=3.
- Branch over stall: in the 2nd stall cycle with LOAD_STALL_CYCLES=3, assert EX_MEM_PCSrc=1. Expect all three flushes=1 and pc_write=1 that cycle, then RUN with no further stall. With HAZ_STATS_EN, flush_count=1.
- Reset mid-stall: drop rst_n during STALL. Expect pc_write=0, id_ex_bubble=1 and counters 0 immediately. After release with no hazard, expect idle outputs on the first cycle.

Source files
------------

// File: rtl/id_hazard_ctrl_pkg.sv
// id_hazard_ctrl_pkg: opcode constants and interlock state encoding shared by the hazard controller.
package id_hazard_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic {
        HZ_RUN,
        HZ_STALL
    } hz_state_e;

endpackage

// File: rtl/id_hazard_ctrl_hz_detect.sv
// id_hazard_ctrl_hz_detect: combinational load-use hazard term.
// Only opcodes that actually read rt as a source may match on rt.
module id_hazard_ctrl_hz_detect
    import id_hazard_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic       memread_i,
    input  logic [4:0] ld_rt_i,
    output logic       hz_o
);

    logic uses_rt;

    assign uses_rt = (opcode_i == OP_RTYPE) | (opcode_i == OP_BEQ) | (opcode_i == OP_SW);
    assign hz_o    = memread_i & (ld_rt_i != 5'd0) &
                     ((ld_rt_i == rs_i) | (uses_rt & (ld_rt_i == rt_i)));

endmodule

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: load-use stall / taken-branch flush interlock for the 5-stage pipeline.
// Define HAZ_STATS_EN to add saturating stall_count / flush_count event counters.
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IF_ID_instrout,
    input  logic        ID_EX_memread,
    input  logic [4:0]  ID_EX_rt,
    input  logic        EX_MEM_PCSrc,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    localparam logic [3:0] CNT_INIT = 4'(LOAD_STALL_CYCLES > 1 ? LOAD_STALL_CYCLES - 2 : 0);

    hz_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       hz, stall_act, br;
    logic       unused_instr;

    assign unused_instr = ^IF_ID_instrout[15:0];

    id_hazard_ctrl_hz_detect u_hz_detect (
        .opcode_i  (IF_ID_instrout[31:26]),
        .rs_i      (IF_ID_instrout[25:21]),
        .rt_i      (IF_ID_instrout[20:16]),
        .memread_i (ID_EX_memread),
        .ld_rt_i   (ID_EX_rt),
        .hz_o      (hz)
    );

    // A resolving branch overrides any stall: the stalled instruction is on the wrong path.
    assign br           = rst_n & EX_MEM_PCSrc;
    assign stall_act    = rst_n & ~EX_MEM_PCSrc & ((state_q == HZ_STALL) | hz);
    assign pc_write     = rst_n & ~stall_act;
    assign if_id_write  = rst_n & ~stall_act;
    assign id_ex_bubble = ~rst_n | stall_act;
    assign if_id_flush  = br;
    assign id_ex_flush  = br;
    assign ex_mem_flush = br;

    always_comb begin
        state_d = EX_MEM_PCSrc ? HZ_RUN :
                  (state_q == HZ_STALL) ? ((cnt_q == 4'd0) ? HZ_RUN : HZ_STALL) :
                  (hz && LOAD_STALL_CYCLES > 1) ? HZ_STALL : HZ_RUN;
        cnt_d   = EX_MEM_PCSrc ? 4'd0 :
                  (state_q == HZ_STALL) ? ((cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1) :
                  hz ? CNT_INIT : 4'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HZ_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_act && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (br && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`endif

endmodule
